regfile_write_bank: RTL and testbench
=====================================

Name: regfile_write_bank

Overview:
- Write side of the CPU's 32 x 64-bit integer register file: a 5-bit write address is decoded to one-hot enables that load one of 32 registers on the rising clock edge.
- Drives the full register array as a packed bus that feeds the existing 32:1 read multiplexers, one per read port.
- Register 31 (XZR) is hardwired to zero: writes to it are discarded and it always reads 0.
- Instantiated once in the decode stage; the write-back stage is the only driver of the write port.

Parameters:
WIDTH, 64, bit width of each register
DEPTH, 32, number of registers; must equal 2**ADDR_W
ADDR_W, 5, write address width
ZERO_REG, 31, index of the hardwired-zero register

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  write enable from write-back stage
wr_addr  input  ADDR_W  destination register index
wr_data  input  WIDTH  data to write
regs  output  DEPTH x WIDTH (packed [31:0][63:0])  current contents of all registers, to read muxes
wr_onehot  output  DEPTH  registered one-hot of the last committed write (debug/verification)
wr_count  output  16  number of committed writes since reset, saturating

Behaviour:
- Reset has priority over everything. At a rising edge with reset=1:
  - all 32 registers go to 0;
  - wr_onehot goes to 0;
  - wr_count goes to 0;
  - any wr_en in that cycle is ignored.
- Decode is combinational: dec[i] = wr_en & (wr_addr == i), one-hot or all-zero.
  - The effective enable masks bit ZERO_REG: en[i] = dec[i] & (i != ZERO_REG).
- Write timing: at a rising edge with reset=0 and en[k]=1, register k loads wr_data. All other registers hold their value.
- Latency:
  - The new value is visible on regs[k] one cycle after the edge. There is no write-through or bypass to readers in the same cycle.
  - Same-cycle read-after-write forwarding is the forwarding unit's job, not this block's.
- regs[ZERO_REG] is a constant 0 at all times, including during and after reset and after any attempted write.
- wr_onehot registers en[] each non-reset edge. It is all-zero on cycles with no committed write and all-zero for a discarded X31 write.
- wr_count increments by 1 on each edge where some en[i]=1.
  - It saturates at 16'hFFFF and does not wrap.
  - X31 writes and wr_en=0 cycles do not count.
- Boundary conditions:
  - wr_addr X/Z while wr_en=0: no register changes.
  - wr_addr changes every cycle: each edge commits only the current address.
  - Back-to-back writes to the same register: last write wins, one per cycle.
  - Reset asserted mid-stream: the register file clears on that edge; the write presented on that edge is lost.
  - Deassertion of reset: the first write is accepted on the first edge with reset=0.
- No X propagation requirement: registers hold their values when wr_en=0, regardless of wr_data.

Test Plan:
- Reset, then sample regs -> all 32 entries 64'h0, wr_count=0, wr_onehot=0.
- wr_en=1, wr_addr=5, wr_data=64'hDEADBEEF_CAFEF00D for one edge -> next cycle regs[5]=64'hDEADBEEF_CAFEF00D, others 0, wr_onehot=32'h0000_0020, wr_count=1.
- Write all 32 addresses with data = addr*64'h0101010101010101 on consecutive edges -> regs[i] matches for i=0..30, regs[31]=0, wr_count=31.
- wr_en=1, wr_addr=31, wr_data=64'hFFFF_FFFF_FFFF_FFFF -> regs[31] stays 0, wr_onehot=0, wr_count unchanged.
- Write regs[7]=64'h1 then regs[7]=64'h2 on consecutive edges -> regs[7]=1 after the first edge, 2 after the second; wr_en=0 with wr_data toggling afterwards -> regs[7] stays 2.
- Load regs[3]=64'hA, then assert reset on the same edge as wr_en=1, wr_addr=4, wr_data=64'hB -> regs[3]=0, regs[4]=0, wr_count=0. Force wr_count to 16'hFFFF and write -> count stays 16'hFFFF.

Source files
------------

// File: rtl/regfile_write_bank.sv
// rtl/regfile_write_bank.sv - write side of the 32 x 64-bit integer register file
// One-hot decoded writes, hardwired-zero register, committed-write tracking.
module regfile_write_bank #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [DEPTH-1:0][WIDTH-1:0] regs,
  output logic [DEPTH-1:0]            wr_onehot,
  output logic [15:0]                 wr_count
);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]            wr_onehot_q, wr_onehot_d;
  logic [15:0]                 wr_count_q, wr_count_d;
  logic [DEPTH-1:0]            dec;
  logic [DEPTH-1:0]            en;

  always_comb begin
    dec = '0;
    en  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dec[i] = wr_en & (wr_addr == ADDR_W'(i));
      en[i]  = dec[i] & (i != ZERO_REG);
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (en[i]) regs_d[i] = wr_data;
    end
    // The zero register never loads, so its flop stays at its reset value.
    regs_d[ZERO_REG] = '0;
    wr_onehot_d = en;
    wr_count_d  = wr_count_q;
    if ((|en) && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q      <= '0;
      wr_onehot_q <= '0;
      wr_count_q  <= '0;
    end else begin
      regs_q      <= regs_d;
      wr_onehot_q <= wr_onehot_d;
      wr_count_q  <= wr_count_d;
    end
  end

  always_comb begin
    regs             = regs_q;
    regs[ZERO_REG]   = '0;
  end

  assign wr_onehot = wr_onehot_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_regfile_write_bank.sv
// tb/tb_regfile_write_bank.sv - scoreboard bench for regfile_write_bank
module tb_regfile_write_bank;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [63:0]       wr_data;
  logic [31:0][63:0] regs;
  logic [31:0]       wr_onehot;
  logic [15:0]       wr_count;

  regfile_write_bank dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .regs      (regs),
    .wr_onehot (wr_onehot),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0][63:0] regs;
    logic [31:0]       oh;
    logic [15:0]       cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  logic [63:0] m_regs [32];
  logic [31:0] m_oh;
  logic [15:0] m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: applies one clock edge of stimulus to the bench copy.
  task automatic model_step(input logic rst, input logic en, input logic [4:0] addr,
                            input logic [63:0] data);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_oh  = '0;
      m_cnt = '0;
    end else begin
      m_oh = '0;
      if (en) begin
        if (addr != 5'd31) begin
          m_regs[addr] = data;
          m_oh         = 32'h1 << addr;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic en, input logic [4:0] addr,
                       input logic [63:0] data, input bit chk);
    exp_t e;
    exp_t got;
    reset   = rst;
    wr_en   = en;
    wr_addr = addr;
    wr_data = data;
    model_step(rst, en, addr, data);
    if (chk) begin
      for (int i = 0; i < 32; i++) e.regs[i] = m_regs[i];
      e.oh  = m_oh;
      e.cnt = m_cnt;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (chk) begin
      got = sb_q.pop_front();
      for (int i = 0; i < 32; i++) check_eq($sformatf("regs[%0d]", i), regs[i], got.regs[i]);
      check_eq("wr_onehot", {32'h0, wr_onehot}, {32'h0, got.oh});
      check_eq("wr_count", {48'h0, wr_count}, {48'h0, got.cnt});
    end
  endtask

  initial begin
    logic [63:0] pat;
    pat = 64'h0101010101010101;
    for (int i = 0; i < 32; i++) m_regs[i] = 'x;
    m_oh  = 'x;
    m_cnt = 'x;

    cycle(1'b1, 1'b1, 5'd9, 64'h1234, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 64'h0, 1'b1);

    cycle(1'b0, 1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 1'b1);
    check_eq("onehot_addr5", {32'h0, wr_onehot}, 64'h0000_0020);

    cycle(1'b1, 1'b0, 5'd0, 64'h0, 1'b1);
    for (int a = 0; a < 32; a++) cycle(1'b0, 1'b1, 5'(a), pat * 64'(a), 1'b1);
    check_eq("count_after_sweep", {48'h0, wr_count}, 64'd31);

    cycle(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    cycle(1'b0, 1'b1, 5'd7, 64'h1, 1'b1);
    cycle(1'b0, 1'b1, 5'd7, 64'h2, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 5'bxxxxx, (k % 2) ? 64'hFFFF_0000_FFFF_0000 : 64'h5555_AAAA_5555_AAAA, 1'b1);
    check_eq("reg7_hold", regs[7], 64'h2);

    cycle(1'b0, 1'b1, 5'd3, 64'hA, 1'b1);
    cycle(1'b1, 1'b1, 5'd4, 64'hB, 1'b1);
    cycle(1'b0, 1'b1, 5'd4, 64'hC, 1'b1);

    for (int k = 0; k < 24; k++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom}, 1'b1);

    cycle(1'b1, 1'b0, 5'd0, 64'h0, 1'b1);
    for (int k = 0; k < 65534; k++) cycle(1'b0, 1'b1, 5'd0, 64'(k), 1'b0);
    cycle(1'b0, 1'b1, 5'd1, 64'h77, 1'b1);
    check_eq("count_at_max", {48'h0, wr_count}, 64'hFFFF);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 5'(k + 2), 64'h99, 1'b1);
    check_eq("count_saturated", {48'h0, wr_count}, 64'hFFFF);

    check_eq("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
